morty_bus_arbiter: RTL
======================

// Module: morty_bus_arbiter
// PURPOSE
//  Shares one Wishbone-classic master port between the IF instruction port (I) and the MEM data port (D).
//  Sits between the fetch/memory stages and the system bus.
//  Grants one transaction at a time, with D priority and an I-starvation guard.
//  Slave terminations are returned to the granted port.
//  A watchdog converts a hung slave into an err response.
// PARAMETERS
//  TIMEOUT_CYCLES  255  cycles from grant with no ack/err before forced err; 0 disables the watchdog
//  MAX_DSTREAK     4    consecutive D grants allowed while I is waiting; then I wins the next grant
// PORTS
//  clk_i         in   1   core clock
//  rst_i         in   1   synchronous reset, active-high
//  iport_addr_i  in   32  instruction address
//  iport_cyc_i   in   1   instruction bus cycle
//  iport_stb_i   in   1   instruction strobe
//  iport_dat_o   out  32  instruction read data (= wbm_dat_i)
//  iport_ack_o   out  1   instruction ack
//  iport_err_o   out  1   instruction err (slave err or timeout)
//  dport_addr_i  in   32  data address
//  dport_dat_i   in   32  store data
//  dport_sel_i   in   4   byte selects
//  dport_we_i    in   1   write enable
//  dport_cyc_i   in   1   data bus cycle
//  dport_stb_i   in   1   data strobe
//  dport_dat_o   out  32  load data (= wbm_dat_i)
//  dport_ack_o   out  1   data ack
//  dport_err_o   out  1   data err (slave err or timeout)
//  wbm_addr_o    out  32  shared bus address
//  wbm_dat_o     out  32  shared bus write data
//  wbm_sel_o     out  4   shared bus byte selects
//  wbm_we_o      out  1   shared bus write enable
//  wbm_cyc_o     out  1   shared bus cycle
//  wbm_stb_o     out  1   shared bus strobe
//  wbm_dat_i     in   32  slave read data
//  wbm_ack_i     in   1   slave ack
//  wbm_err_i     in   1   slave err
// BEHAVIOUR
//  FSM states: IDLE, GNT_I, GNT_D. State is registered; bus muxing and response routing are combinational from state.
//  Reset: state=IDLE, watchdog=0, dstreak=0.
//   In IDLE: wbm_cyc/stb/we=0, wbm_addr/dat/sel=0, all ack/err=0.
//   *_dat_o always equals wbm_dat_i.
//  Requests: ireq = iport_cyc_i&iport_stb_i; dreq = dport_cyc_i&dport_stb_i.
//  IDLE transitions:
//   dreq & ~(ireq & dstreak==MAX_DSTREAK) -> GNT_D
//   else ireq -> GNT_I
//   else stay in IDLE
//  Latency: request sampled at edge N; wbm_cyc_o/wbm_stb_o high from cycle N+1.
//  GNT_x drives the bus:
//   wbm_addr/dat/sel/we follow port x; the I port drives we=0, sel=4'hF, dat=0.
//   wbm_cyc_o = x_cyc_i; wbm_stb_o = x_cyc_i & x_stb_i.
//  Response routing (same cycle, combinational):
//   x_ack_o = wbm_ack_i; x_err_o = wbm_err_i | wd_fire.
//   The other port's ack/err = 0.
//  GNT_x exits to IDLE on ack | err | wd_fire | ~x_cyc_i.
//   ~x_cyc_i is an abort, e.g. IF kill on branch/jump.
//   There is always at least one IDLE cycle between grants; there is no back-to-back pipelining.
//   Any ack/err arriving while in IDLE, or after an abort, is dropped.
//  Watchdog:
//   Cleared on entry to GNT_x; increments each GNT cycle with no ack/err.
//   wd_fire = (TIMEOUT_CYCLES!=0) & (watchdog==TIMEOUT_CYCLES-1) & ~ack & ~err.
//   On wd_fire, wbm_cyc_o/wbm_stb_o are forced 0 in that cycle.
//   The counter is wide enough for TIMEOUT_CYCLES-1 and never wraps.
//  dstreak:
//   +1 (saturating at MAX_DSTREAK) on each GNT_D exit while ireq=1.
//   Cleared when GNT_I is entered, or in any cycle with ireq=0.
//  Simultaneous events:
//   ack and err together: both are forwarded; the master treats it as err.
//   ack on the wd_fire cycle: ack wins, no err.
//  Reset mid-transaction:
//   rst_i high at edge N forces IDLE, so wbm_cyc_o=0 in cycle N+1.
//   Responses in reset cycles are not forwarded once state is IDLE.
// TESTING
//  1. I-only read at 0x100, slave acks 2 cycles after stb -> iport_ack_o=1 for 1 cycle with data; dport_ack_o stays 0.
//  2. ireq and dreq in same cycle, dstreak=0 -> GNT_D first; after D ack, one IDLE cycle, then GNT_I.
//  3. dreq every cycle for 5 transactions plus ireq held, MAX_DSTREAK=4 -> grant order D,D,D,D,I,D.
//  4. D write, slave never responds, TIMEOUT_CYCLES=8 -> dport_err_o pulse in 8th GNT cycle, wbm_cyc_o=0 that cycle, state IDLE next.
//  5. GNT_I, iport_cyc_i dropped before ack, slave acks next cycle -> ack dropped; iport_ack_o and dport_ack_o stay 0.
//  6. rst_i asserted for 1 cycle during GNT_D -> wbm_cyc_o=0 in the next cycle, all ack/err=0, dstreak=0.

Source files
------------

// File: rtl/morty_bus_arbiter.sv
// Shares one Wishbone-classic master port between the instruction (I) and data (D) ports.
// One transaction at a time; D has priority, bounded by a streak limit so I cannot starve.
// A watchdog turns a hung slave into an err response on the granted port.
module morty_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_DSTREAK    = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] iport_addr_i,
    input  logic        iport_cyc_i,
    input  logic        iport_stb_i,
    output logic [31:0] iport_dat_o,
    output logic        iport_ack_o,
    output logic        iport_err_o,
    input  logic [31:0] dport_addr_i,
    input  logic [31:0] dport_dat_i,
    input  logic [3:0]  dport_sel_i,
    input  logic        dport_we_i,
    input  logic        dport_cyc_i,
    input  logic        dport_stb_i,
    output logic [31:0] dport_dat_o,
    output logic        dport_ack_o,
    output logic        dport_err_o,
    output logic [31:0] wbm_addr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    // Watchdog only needs to reach TIMEOUT_CYCLES-1; streak only needs to reach MAX_DSTREAK.
    localparam int unsigned WdW  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned StkW = (MAX_DSTREAK > 1) ? $clog2(MAX_DSTREAK + 1) : 1;
    localparam logic [WdW-1:0]  WdLast =
        (TIMEOUT_CYCLES == 0) ? '0 : WdW'(TIMEOUT_CYCLES - 1);
    localparam logic [StkW-1:0] StkMax = StkW'(MAX_DSTREAK);

    typedef enum logic [1:0] {StIdle, StGntI, StGntD} state_e;

    state_e          state_q, state_d;
    logic [WdW-1:0]  wd_q, wd_d;
    logic [StkW-1:0] stk_q, stk_d;

    logic ireq, dreq, resp, wd_fire, gnt_exit;

    // State, watchdog and D-streak registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            wd_q    <= '0;
            stk_q   <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            stk_q   <= stk_d;
        end
    end

    // Grant decision, bus muxing, response routing and counter next-state.
    always_comb begin
        ireq     = iport_cyc_i & iport_stb_i;
        dreq     = dport_cyc_i & dport_stb_i;
        resp     = wbm_ack_i | wbm_err_i;
        // An ack landing on the timeout cycle wins, so the watchdog stays quiet.
        wd_fire  = (TIMEOUT_CYCLES != 0) && (state_q != StIdle) && (wd_q == WdLast) && !resp;
        gnt_exit = 1'b0;

        state_d = state_q;
        wd_d    = wd_q;
        stk_d   = stk_q;

        iport_dat_o = wbm_dat_i;
        dport_dat_o = wbm_dat_i;
        iport_ack_o = 1'b0;
        iport_err_o = 1'b0;
        dport_ack_o = 1'b0;
        dport_err_o = 1'b0;
        wbm_addr_o  = '0;
        wbm_dat_o   = '0;
        wbm_sel_o   = '0;
        wbm_we_o    = 1'b0;
        wbm_cyc_o   = 1'b0;
        wbm_stb_o   = 1'b0;

        unique case (state_q)
            StIdle: begin
                wd_d = '0;
                if (dreq && !(ireq && (stk_q == StkMax))) begin
                    state_d = StGntD;
                end else if (ireq) begin
                    state_d = StGntI;
                end
            end
            StGntI: begin
                wbm_addr_o  = iport_addr_i;
                wbm_sel_o   = 4'hF;
                wbm_cyc_o   = iport_cyc_i & ~wd_fire;
                wbm_stb_o   = iport_cyc_i & iport_stb_i & ~wd_fire;
                iport_ack_o = wbm_ack_i;
                iport_err_o = wbm_err_i | wd_fire;
                gnt_exit    = resp | wd_fire | ~iport_cyc_i;
            end
            StGntD: begin
                wbm_addr_o  = dport_addr_i;
                wbm_dat_o   = dport_dat_i;
                wbm_sel_o   = dport_sel_i;
                wbm_we_o    = dport_we_i;
                wbm_cyc_o   = dport_cyc_i & ~wd_fire;
                wbm_stb_o   = dport_cyc_i & dport_stb_i & ~wd_fire;
                dport_ack_o = wbm_ack_i;
                dport_err_o = wbm_err_i | wd_fire;
                gnt_exit    = resp | wd_fire | ~dport_cyc_i;
            end
            default: state_d = StIdle;
        endcase

        if (state_q != StIdle) begin
            if (gnt_exit) begin
                state_d = StIdle;
            end else if (TIMEOUT_CYCLES != 0) begin
                wd_d = wd_q + 1'b1;
            end
        end

        if (!ireq) begin
            stk_d = '0;
        end else if (state_q == StIdle && state_d == StGntI) begin
            stk_d = '0;
        end else if (state_q == StGntD && gnt_exit && stk_q != StkMax) begin
            stk_d = stk_q + 1'b1;
        end
    end

endmodule
